// File: rtl/reg_master_if.sv
// Host request/response handshakes plus the 2-bit-op register bus, as seen by reg_master.
// The master modport is the initiator's view; slave is the host and responder side.
interface reg_master_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DWIDTH-1:0] rsp_rdata;

    logic [1:0]        reg_op;
    logic [AWIDTH-1:0] reg_addr;
    logic [DWIDTH-1:0] reg_wdata;
    logic [DWIDTH-1:0] reg_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, reg_rdata,
        output req_ready, rsp_valid, rsp_write, rsp_rdata, reg_op, reg_addr, reg_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, reg_rdata,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata, reg_op, reg_addr, reg_wdata
    );
endinterface

// File: rtl/reg_master.sv
// Register-bus initiator: turns one host request into exactly one RD/WR bus op and returns
// one response, with saturating completion counters. Only one transaction is ever in flight.
module reg_master #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    reg_master_if.master      bus,
    output logic              busy,
    output logic [CWIDTH-1:0] wr_cnt,
    output logic [CWIDTH-1:0] rd_cnt
);

    localparam logic [1:0] OpNop = 2'b00;
    localparam logic [1:0] OpRd  = 2'b01;
    localparam logic [1:0] OpWr  = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CWIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CWIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic              accept;
    logic              complete;

    assign accept   = (state_q == StIdle) && bus.req_valid;
    assign complete = (state_q == StResp) && bus.rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.req_valid) state_d = StIssue;
            StIssue:   state_d = write_q ? StResp : StCapture;
            StCapture: state_d = StResp;
            StResp:    if (bus.rsp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state; bus address/data only move on accept so they hold across NOPs.
    always_comb begin
        op_d        = OpNop;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        if (accept) begin
            op_d    = bus.req_write ? OpWr : OpRd;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            write_d = bus.req_write;
        end

        if (state_q == StIssue && write_q) begin
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
        end

        // Responder latency is fixed at one cycle, so read data is valid in CAPTURE.
        if (state_q == StCapture) begin
            rsp_write_d = 1'b0;
            rsp_rdata_d = bus.reg_rdata;
        end

        if (complete) begin
            if (write_q && !(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CWIDTH'(1);
            if (!write_q && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CWIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OpNop;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        busy          = (state_q != StIdle);
        bus.rsp_write = rsp_write_q;
        bus.rsp_rdata = rsp_rdata_q;
        bus.reg_op    = op_q;
        bus.reg_addr  = addr_q;
        bus.reg_wdata = wdata_q;
        wr_cnt        = wr_cnt_q;
        rd_cnt        = rd_cnt_q;
    end

endmodule

// File: tb/tb_reg_master.sv
// Directed bench for reg_master: vector table against a 2-register responder, plus
// hand-written backpressure, streaming, mid-read reset and counter saturation sequences.
module tb_reg_master;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic        busy2;
    logic [1:0]  wr_cnt2;
    logic [1:0]  rd_cnt2;

    int errors = 0;
    int checks = 0;

    reg_master_if #(.DWIDTH(8), .AWIDTH(8)) bus ();
    reg_master_if #(.DWIDTH(8), .AWIDTH(8)) bus2 ();

    reg_master #(.DWIDTH(8), .AWIDTH(8), .CWIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.master),
        .busy   (busy),
        .wr_cnt (wr_cnt),
        .rd_cnt (rd_cnt)
    );

    reg_master #(.DWIDTH(8), .AWIDTH(8), .CWIDTH(2)) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus2.master),
        .busy   (busy2),
        .wr_cnt (wr_cnt2),
        .rd_cnt (rd_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-register responder decoding addr[0]; read data appears the cycle after RD.
    logic [7:0] mem [2];
    always @(posedge clk) begin
        if (bus.reg_op == 2'b10) mem[bus.reg_addr[0]] <= bus.reg_wdata;
        if (bus.reg_op == 2'b01) bus.reg_rdata <= mem[bus.reg_addr[0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction from a negedge in IDLE with rsp_ready released after rsp_valid.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int opc, output logic [1:0] op_seen,
                       output logic [7:0] addr_seen, output logic [7:0] wdata_seen,
                       output logic rw, output logic [7:0] rdata);
        int n;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        opc = 0;
        op_seen = 2'b00;
        addr_seen = 8'h00;
        wdata_seen = 8'h00;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.reg_op != 2'b00) begin
                opc++;
                op_seen = bus.reg_op;
                addr_seen = bus.reg_addr;
                wdata_seen = bus.reg_wdata;
            end
            @(negedge clk);
            lat++;
        end
        if (bus.reg_op != 2'b00) opc++;
        rw = bus.rsp_write;
        rdata = bus.rsp_rdata;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         lat;
        logic [7:0] rdata;
    } vec_t;

    vec_t vt[7];

    initial begin
        int lat, opc, n, exp_wr, exp_rd, n_acc, n_rsp;
        int acc_cyc[4];
        logic [1:0] op_seen;
        logic [7:0] addr_seen, wdata_seen, rdata;
        logic rw, rdy, rv, saw;
        logic [1:0] sat_exp[5];

        vt[0] = '{w: 1'b1, a: 8'h01, d: 8'hA5, lat: 2, rdata: 8'h00};
        vt[1] = '{w: 1'b0, a: 8'h01, d: 8'h00, lat: 3, rdata: 8'hA5};
        vt[2] = '{w: 1'b1, a: 8'h00, d: 8'h3C, lat: 2, rdata: 8'h00};
        vt[3] = '{w: 1'b0, a: 8'h00, d: 8'h11, lat: 3, rdata: 8'h3C};
        vt[4] = '{w: 1'b1, a: 8'h41, d: 8'h5A, lat: 2, rdata: 8'h00};
        vt[5] = '{w: 1'b0, a: 8'h01, d: 8'hFF, lat: 3, rdata: 8'h5A};
        vt[6] = '{w: 1'b0, a: 8'h80, d: 8'h22, lat: 3, rdata: 8'h3C};
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;
        sat_exp[4] = 2'd3;

        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0;
        bus2.req_write = 1'b0;
        bus2.req_addr  = 8'h00;
        bus2.req_wdata = 8'h00;
        bus2.rsp_ready = 1'b0;
        bus2.reg_rdata = 8'h00;

        // Reset asserted between edges must take effect without a clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_reg_op", {30'd0, bus.reg_op}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        chk("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        exp_wr = 0;
        exp_rd = 0;
        for (int i = 0; i < 7; i++) begin
            txn(vt[i].w, vt[i].a, vt[i].d, lat, opc, op_seen, addr_seen, wdata_seen, rw, rdata);
            if (vt[i].w) exp_wr++;
            else exp_rd++;
            chk("vec_latency", lat, vt[i].lat);
            chk("vec_op_cycles", opc, 32'd1);
            chk("vec_op", {30'd0, op_seen}, vt[i].w ? 32'd2 : 32'd1);
            chk("vec_addr", {24'd0, addr_seen}, {24'd0, vt[i].a});
            chk("vec_wdata", {24'd0, wdata_seen}, {24'd0, vt[i].d});
            chk("vec_rsp_write", {31'd0, rw}, {31'd0, vt[i].w});
            chk("vec_rsp_rdata", {24'd0, rdata}, {24'd0, vt[i].rdata});
            chk("vec_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
            chk("vec_wr_cnt", {16'd0, wr_cnt}, exp_wr);
            chk("vec_rd_cnt", {16'd0, rd_cnt}, exp_rd);
            chk("vec_addr_hold", {24'd0, bus.reg_addr}, {24'd0, vt[i].a});
        end

        // Backpressured read of addr 0 with a second request waiting behind it.
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h01;
        bus.req_wdata = 8'h77;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h3C);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_rd_cnt", {16'd0, rd_cnt}, exp_rd + 1);
        chk("bp_idle_after", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_second_op", {30'd0, bus.reg_op}, 32'd2);
        chk("bp_second_addr", {24'd0, bus.reg_addr}, 32'h01);
        chk("bp_second_wdata", {24'd0, bus.reg_wdata}, 32'h77);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_wr_cnt", {16'd0, wr_cnt}, exp_wr + 1);
        exp_wr++;
        exp_rd++;

        // Four writes streamed with both valid and ready held high.
        n_acc = 0;
        n_rsp = 0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && n_rsp < 4; c++) begin
            if (n_acc < 4) begin
                bus.req_write = 1'b1;
                bus.req_addr  = 8'(n_acc);
                bus.req_wdata = 8'(8'hC0 + n_acc);
                bus.req_valid = 1'b1;
            end else begin
                bus.req_valid = 1'b0;
            end
            rdy = bus.req_ready && bus.req_valid;
            rv  = bus.rsp_valid;
            @(posedge clk);
            if (rdy) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (rv) n_rsp++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("stream_accepts", n_acc, 32'd4);
        chk("stream_responses", n_rsp, 32'd4);
        for (int i = 1; i < 4; i++) chk("stream_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);
        chk("stream_wr_cnt", {16'd0, wr_cnt}, exp_wr + 4);
        chk("stream_mem3", {24'd0, mem[1]}, 32'hC3);

        // Reset while the read sits in CAPTURE; nothing may complete.
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h01;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_in_capture", {30'd0, bus.reg_op, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        chk("mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        saw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid) saw = 1'b1;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        chk("mid_no_rsp", {31'd0, saw}, 32'd0);
        chk("mid_rd_cnt_after", {16'd0, rd_cnt}, 32'd0);
        txn(1'b1, 8'h01, 8'hA5, lat, opc, op_seen, addr_seen, wdata_seen, rw, rdata);
        chk("post_wr_lat", lat, 32'd2);
        chk("post_wr_op", {30'd0, op_seen}, 32'd2);
        chk("post_wr_opc", opc, 32'd1);
        chk("post_wr_rsp_write", {31'd0, rw}, 32'd1);
        txn(1'b0, 8'h01, 8'h00, lat, opc, op_seen, addr_seen, wdata_seen, rw, rdata);
        chk("post_rd_lat", lat, 32'd3);
        chk("post_rd_rdata", {24'd0, rdata}, 32'hA5);
        chk("post_cnts", {wr_cnt, rd_cnt}, {16'd1, 16'd1});

        // Saturating 2-bit write counter on the second instance.
        bus2.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("sat_req_ready", {31'd0, bus2.req_ready}, 32'd1);
            bus2.req_write = 1'b1;
            bus2.req_addr  = 8'(i);
            bus2.req_wdata = 8'(i);
            bus2.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus2.req_valid = 1'b0;
            n = 0;
            while (!bus2.rsp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            chk("sat_wr_cnt", {30'd0, wr_cnt2}, {30'd0, sat_exp[i]});
        end
        chk("sat_rd_cnt", {30'd0, rd_cnt2}, 32'd0);
        chk("sat_idle", {31'd0, busy2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
